// File: rtl/mem_port_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
// The optional starvation guard is enabled by MEM_PORT_ARB_STARVE_GUARD_EN.
package mem_port_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    OWN_IF = 2'd1,
    OWN_LS = 2'd2
  } owner_t;
endpackage

// File: rtl/mem_port_arb_pick.sv
// Grant selection between fetch and load/store; LS has priority.
// With MEM_PORT_ARB_STARVE_GUARD_EN, IF is forced after STARVE_MAX LS grants made while IF waited.
module mem_port_arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_valid,
  input  logic ls_valid,
  output logic grant_if,
  output logic grant_ls
);

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_if;

  assign force_if = if_valid & (starve_cnt == CNT_W'(STARVE_MAX));
  assign grant_ls = arb_en & ls_valid & ~force_if;
  assign grant_if = arb_en & if_valid & ~grant_ls;

  // Counts LS grants that bypassed a waiting fetch; cannot pass STARVE_MAX since IF is then forced.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_ls && if_valid) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= starve_cnt;
    end
  end
`else
  logic unused_pick;

  assign unused_pick = ^{clk, rst, STARVE_MAX[0]};
  assign grant_ls    = arb_en & ls_valid;
  assign grant_if    = arb_en & if_valid & ~ls_valid;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction at a time.
// Optional starvation guard (in mem_port_arb_pick) is enabled by MEM_PORT_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wen,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_req_ready,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                busy
);

  state_t state;
  owner_t owner;
  logic   arb_en;
  logic   grant_if;
  logic   grant_ls;

  // Gating with rst keeps the ready outputs low while reset is held.
  assign arb_en       = rst & (state == IDLE);
  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  mem_port_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (arb_en),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  // Transaction FSM with registered memory request and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= NONE;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      if_rsp_valid  <= 1'b0;
      if_rsp_data   <= '0;
      ls_rsp_valid  <= 1'b0;
      ls_rsp_data   <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ls) begin
            mem_req_addr  <= ls_req_addr;
            mem_req_wen   <= ls_req_wen;
            mem_req_wdata <= ls_req_wdata;
            mem_req_wmask <= ls_req_wmask;
            owner         <= OWN_LS;
            mem_req_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= REQ;
          end else if (grant_if) begin
            mem_req_addr  <= if_req_addr;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            owner         <= OWN_IF;
            mem_req_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= REQ;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end else begin
            state <= REQ;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (owner == OWN_LS) begin
              ls_rsp_valid <= 1'b1;
              ls_rsp_data  <= mem_req_wen ? '0 : mem_rsp_data;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= mem_rsp_data;
            end
            state <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        RESP: begin
          if_rsp_valid <= 1'b0;
          ls_rsp_valid <= 1'b0;
          owner        <= NONE;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          mem_req_valid <= 1'b0;
          if_rsp_valid  <= 1'b0;
          ls_rsp_valid  <= 1'b0;
          owner         <= NONE;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences,
// and randomized traffic against a cycle-stamped transaction model.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MW   = 4;
  localparam int SMAX = 4;
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_rsp_data;
  logic          ls_req_valid, ls_req_wen, ls_req_ready, ls_rsp_valid;
  logic [AW-1:0] ls_req_addr;
  logic [DW-1:0] ls_req_wdata, ls_rsp_data;
  logic [MW-1:0] ls_req_wmask;
  logic          mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, busy;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_rsp_data;
  logic [MW-1:0] mem_req_wmask;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  typedef struct {
    logic          if_v;
    logic          ls_v;
    logic          wen;
    logic [31:0]   addr_if;
    logic [31:0]   addr_ls;
    logic [31:0]   wdata;
    logic [3:0]    wmask;
    logic [31:0]   mdata;
    logic          exp_if;
    logic [31:0]   exp_addr;
    logic          exp_wen;
    logic [31:0]   exp_data;
  } vec_t;

  vec_t        vecs[5];
  int          total = 0;
  int          bad = 0;
  logic        auto_mem;
  logic [31:0] auto_data;

  // random-test model state
  logic        have, own_ls, e_wen, if_acc, ls_acc, have0, exp_mv, exp_busy, exp_pulse, exp_ls_g, exp_if_g;
  int          t_acc, t_iss, t_rsp, starve, g, budget;
  logic [31:0] e_addr, e_wdata, e_rsp, last_if, last_ls;
  logic [3:0]  e_mask;
  logic [4:0]  seq;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] all_out();
    all_out = {21'd0, if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid,
               ls_rsp_data, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
               mem_req_wmask, busy};
  endfunction

  task automatic idle_inputs();
    if_req_valid = 1'b0; if_req_addr = 32'h0;
    ls_req_valid = 1'b0; ls_req_addr = 32'h0; ls_req_wen = 1'b0;
    ls_req_wdata = 32'h0; ls_req_wmask = 4'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
  endtask

  // Called at the negedge; advances to just after the next rising edge.
  task automatic tick();
    logic hs;
    hs = mem_req_valid & mem_req_ready;
    @(posedge clk); #1;
    if (auto_mem) begin
      mem_req_ready = 1'b1;
      mem_rsp_valid = hs;
      mem_rsp_data  = hs ? auto_data : 32'h0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_out(), 160'd0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    auto_mem = 1'b1; auto_data = v.mdata; mem_req_ready = 1'b1;
    if_req_valid = v.if_v; if_req_addr = v.addr_if;
    ls_req_valid = v.ls_v; ls_req_addr = v.addr_ls; ls_req_wen = v.wen;
    ls_req_wdata = v.wdata; ls_req_wmask = v.wmask;
    @(negedge clk);
    chk($sformatf("v%0d_ready", i), {if_req_ready, ls_req_ready}, {v.exp_if, ~v.exp_if});
    tick();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_mem_req", i), {mem_req_valid, mem_req_addr, mem_req_wen}, {1'b1, v.exp_addr, v.exp_wen});
    if (!v.exp_if) chk($sformatf("v%0d_mem_wr", i), {mem_req_wdata, mem_req_wmask}, {v.wdata, v.wmask});
    tick();
    @(negedge clk);
    chk($sformatf("v%0d_wait", i), {mem_req_valid, busy, if_rsp_valid, ls_rsp_valid}, 4'b0100);
    tick();
    @(negedge clk);
    chk($sformatf("v%0d_pulse", i), {if_rsp_valid, ls_rsp_valid}, {v.exp_if, ~v.exp_if});
    chk($sformatf("v%0d_data", i), v.exp_if ? if_rsp_data : ls_rsp_data, v.exp_data);
    tick();
    @(negedge clk);
    chk($sformatf("v%0d_after", i), {if_rsp_valid, ls_rsp_valid, busy, if_req_ready, ls_req_ready}, 5'b0);
    tick();
    @(negedge clk);
    chk($sformatf("v%0d_no_issue", i), {mem_req_valid, busy}, 2'b00);
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h80000000, 32'h0, 32'h0, 4'h0, 32'h00100093, 1'b1, 32'h80000000, 1'b0, 32'h00100093};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h80000004, 32'h80001000, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 32'h80001000, 1'b0, 32'hCAFEF00D};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h80002000, 32'h11223344, 4'hF, 32'h55555555, 1'b0, 32'h80002000, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h00000000, 32'h0, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 4'h0, 32'h00000013, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h00000013};
    auto_mem = 1'b0; auto_data = 32'h0;
    do_reset();
    for (int i = 0; i < 5; i++) run_vec(i);

    // both valid: LS first, IF held and served afterwards
    auto_mem = 1'b1; mem_req_ready = 1'b1; auto_data = 32'hA0A0A0A0;
    if_req_valid = 1'b1; if_req_addr = 32'h80000010;
    ls_req_valid = 1'b1; ls_req_addr = 32'h80001000; ls_req_wen = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) chk("t2_grant_ls", {ls_req_ready, if_req_ready}, 2'b10);
      if (c >= 1 && c <= 3) chk("t2_if_waits", if_req_ready, 1'b0);
      if (c == 3) chk("t2_ls_rsp", {ls_rsp_valid, ls_rsp_data, if_rsp_valid}, {1'b1, 32'hA0A0A0A0, 1'b0});
      if (c == 4) begin chk("t2_if_ready_after", if_req_ready, 1'b1); auto_data = 32'h0B0B0B0B; end
      if (c == 5) chk("t2_if_addr", {mem_req_valid, mem_req_addr}, {1'b1, 32'h80000010});
      if (c == 7) chk("t2_if_rsp", {if_rsp_valid, if_rsp_data, ls_rsp_valid}, {1'b1, 32'h0B0B0B0B, 1'b0});
      tick();
      if (c == 0) ls_req_valid = 1'b0;
      if (c == 4) if_req_valid = 1'b0;
    end

    // store with memory stalled three cycles
    auto_mem = 1'b0; idle_inputs();
    ls_req_valid = 1'b1; ls_req_addr = 32'h80003000; ls_req_wen = 1'b1;
    ls_req_wdata = 32'hDEADBEEF; ls_req_wmask = 4'b0011;
    @(negedge clk);
    chk("t3_ls_ready", ls_req_ready, 1'b1);
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      mem_req_ready = (c == 3);
      @(negedge clk);
      chk($sformatf("t3_stable%0d", c), {mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask},
          {1'b1, 32'h80003000, 1'b1, 32'hDEADBEEF, 4'b0011});
      tick();
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h12345678;
    @(negedge clk);
    chk("t3_wait", {mem_req_valid, ls_rsp_valid}, 2'b00);
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("t3_store_ack", {ls_rsp_valid, ls_rsp_data, if_rsp_valid}, {1'b1, 32'h0, 1'b0});
    tick();
    @(negedge clk);
    chk("t3_done", {ls_rsp_valid, busy}, 2'b00);
    tick();

    // spurious memory responses in IDLE and in REQ
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0BAD0;
    @(negedge clk);
    chk("t4_idle_busy", busy, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("t4_idle_quiet", {if_rsp_valid, ls_rsp_valid, busy, if_rsp_data, ls_rsp_data}, {3'b000, 32'h0B0B0B0B, 32'h0});
    tick();
    if_req_valid = 1'b1; if_req_addr = 32'h80000020;
    @(negedge clk);
    chk("t4_if_ready", if_req_ready, 1'b1);
    tick();
    if_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD1BAD1;
    @(negedge clk);
    chk("t4_req_valid", mem_req_valid, 1'b1);
    tick();
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    chk("t4_still_req", {mem_req_valid, if_rsp_valid, ls_rsp_valid}, 3'b100);
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00000513;
    @(negedge clk);
    chk("t4_wait", mem_req_valid, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("t4_real_rsp", {if_rsp_valid, if_rsp_data}, {1'b1, 32'h00000513});
    tick();

    // reset while waiting for the memory response
    ls_req_valid = 1'b1; ls_req_addr = 32'h80004000; ls_req_wen = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    chk("t5_ls_ready", ls_req_ready, 1'b1);
    tick();
    ls_req_valid = 1'b0;
    @(negedge clk);
    tick();
    mem_req_ready = 1'b0;
    #2 rst = 1'b0;
    #1 chk("t5_rst_outputs", all_out(), 160'd0);
    @(posedge clk); #1;
    rst = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h77777777;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t5_no_rsp%0d", c), {if_rsp_valid, ls_rsp_valid, busy, mem_req_valid}, 4'b0);
      tick();
      mem_rsp_valid = 1'b0;
    end

    // grant sequence with both requesters held valid
    do_reset();
    auto_mem = 1'b1; mem_req_ready = 1'b1; auto_data = 32'h1;
    if_req_valid = 1'b1; if_req_addr = 32'h80000100;
    ls_req_valid = 1'b1; ls_req_addr = 32'h80005000; ls_req_wen = 1'b0;
    g = 0; budget = 0; seq = 5'b0;
    while (g < 5 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (ls_req_ready) begin
        seq[g] = 1'b0; g++;
      end else if (if_req_ready) begin
        seq[g] = 1'b1; g++;
      end
      tick();
      if (g == 5) if_req_valid = 1'b0;
    end
    chk("t6_grant_count", g, 5);
    chk("t6_grant_seq", seq, GUARD ? 5'b10000 : 5'b00000);

    // randomized traffic against the transaction model
    auto_mem = 1'b0;
    do_reset();
    have = 1'b0; own_ls = 1'b0; e_wen = 1'b0; t_acc = -1; t_iss = -1; t_rsp = -1; starve = 0;
    e_addr = 32'h0; e_wdata = 32'h0; e_mask = 4'h0; e_rsp = 32'h0; last_if = 32'h0; last_ls = 32'h0;
    if_acc = 1'b0; ls_acc = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (if_acc || (if_req_valid && $urandom_range(15) == 0)) if_req_valid = 1'b0;
      else if (!if_req_valid && $urandom_range(2) == 0) begin
        if_req_valid = 1'b1; if_req_addr = $urandom & 32'hFFFFFFFC;
      end
      if (ls_acc || (ls_req_valid && $urandom_range(15) == 0)) ls_req_valid = 1'b0;
      else if (!ls_req_valid && $urandom_range(2) == 0) begin
        ls_req_valid = 1'b1; ls_req_addr = $urandom; ls_req_wen = 1'($urandom_range(1));
        ls_req_wdata = $urandom; ls_req_wmask = 4'($urandom_range(15));
      end
      mem_req_ready = ($urandom_range(2) != 0);
      if (have && t_iss >= 0 && t_rsp < 0) mem_rsp_valid = 1'($urandom_range(1));
      else mem_rsp_valid = ($urandom_range(7) == 0);
      mem_rsp_data = $urandom;
      @(negedge clk);
      have0     = have;
      exp_mv    = have && k > t_acc && t_iss < 0;
      exp_busy  = have && k > t_acc;
      exp_pulse = have && t_rsp >= 0 && k == t_rsp + 1;
      if (exp_pulse && own_ls) last_ls = e_rsp;
      if (exp_pulse && !own_ls) last_if = e_rsp;
      chk("rnd_mem_req_valid", mem_req_valid, exp_mv);
      chk("rnd_busy", busy, exp_busy);
      chk("rnd_rsp_valid", {if_rsp_valid, ls_rsp_valid}, {exp_pulse && !own_ls, exp_pulse && own_ls});
      chk("rnd_rsp_data", {if_rsp_data, ls_rsp_data}, {last_if, last_ls});
      if (exp_mv) begin
        chk("rnd_req_fields", {mem_req_addr, mem_req_wen}, {e_addr, e_wen});
        if (own_ls) chk("rnd_req_wr", {mem_req_wdata, mem_req_wmask}, {e_wdata, e_mask});
      end
      exp_ls_g = !have0 && ls_req_valid && !(GUARD && if_req_valid && starve == SMAX);
      exp_if_g = !have0 && if_req_valid && !exp_ls_g;
      chk("rnd_ready", {if_req_ready, ls_req_ready}, {exp_if_g, exp_ls_g});
      if (exp_pulse) have = 1'b0;
      if (exp_mv && mem_req_ready) t_iss = k;
      else if (have && t_iss >= 0 && t_rsp < 0 && mem_rsp_valid) begin
        t_rsp = k;
        e_rsp = (own_ls && e_wen) ? 32'h0 : mem_rsp_data;
      end
      if (exp_ls_g || exp_if_g) begin
        have = 1'b1; t_acc = k; t_iss = -1; t_rsp = -1; own_ls = exp_ls_g;
        e_addr  = exp_ls_g ? ls_req_addr : if_req_addr;
        e_wen   = exp_ls_g & ls_req_wen;
        e_wdata = ls_req_wdata; e_mask = ls_req_wmask;
        if (exp_if_g) starve = 0;
        else if (if_req_valid) starve++;
      end
      if_acc = if_req_valid & if_req_ready;
      ls_acc = ls_req_valid & ls_req_ready;
      tick();
    end
    idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
